// File: rtl/crc16_arb_pkg.sv
// rtl/crc16_arb_pkg.sv - shared types and round-robin helper for the CRC16 arbiter
package crc16_arb_pkg;

    localparam int CRC_W   = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [2:0] {IDLE, INIT, STREAM, WAIT, RESP} state_t;

    // First set bit of req strictly after ptr, wrapping within the n populated lanes.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                    input int ptr,
                                                    input int n);
        logic [MAX_REQ-1:0] pick;
        int idx;
        pick = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k <= n && pick == '0 && req[idx[2:0]]) pick[idx[2:0]] = 1'b1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/crc16_arbiter_rr_select.sv
// rtl/crc16_arbiter_rr_select.sv - combinational round-robin picker
module rr_select
    import crc16_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_req
);

    logic [MAX_REQ-1:0] pick;

    assign pick    = rr_pick(MAX_REQ'(req), int'(rr_ptr), NUM_REQ);
    assign winner  = pick[NUM_REQ-1:0];
    assign any_req = |pick;

endmodule

// File: rtl/crc16_arbiter.sv
// rtl/crc16_arbiter.sv - round-robin sharing of one CRC16 engine between parser lanes
module crc16_arbiter
    import crc16_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_WORDS = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*CRC_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     err,
    output logic [CRC_W-1:0]         crc_result,
    output logic                     busy,
    output logic                     eng_init,
    output logic                     eng_valid,
    output logic [CRC_W-1:0]         eng_data,
    output logic                     eng_last,
    input  logic                     eng_done,
    input  logic [CRC_W-1:0]         eng_result
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WC_W  = $clog2(MAX_WORDS + 1);
    localparam int TMO_W = $clog2(TIMEOUT);

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt, winner_idx;
    logic [WC_W-1:0]    word_cnt, word_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, done_nxt, winner;
    logic               any_req, err_nxt;
    logic               eng_init_nxt, eng_valid_nxt, eng_last_nxt;
    logic [CRC_W-1:0]   eng_data_nxt, crc_nxt, sel_data;
    logic               sel_valid, sel_last, req_held;

    rr_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_select (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        winner_idx = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) winner_idx = PTR_W'(i);
            if (gnt[i])    sel_data   = req_data[i*CRC_W +: CRC_W];
        end
    end

    assign sel_valid = |(req_valid & gnt);
    assign sel_last  = |(req_last & gnt);
    assign req_held  = |(req & gnt);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        rr_ptr_nxt    = rr_ptr;
        word_cnt_nxt  = word_cnt;
        tmo_cnt_nxt   = tmo_cnt;
        eng_init_nxt  = 1'b0;
        eng_valid_nxt = 1'b0;
        eng_last_nxt  = 1'b0;
        eng_data_nxt  = '0;
        done_nxt      = '0;
        err_nxt       = err;
        crc_nxt       = crc_result;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_nxt    = winner;
                    rr_ptr_nxt = winner_idx;
                    state_nxt  = INIT;
                end
            end
            INIT, STREAM, WAIT: begin
                // A dropped request abandons the frame silently; rr_ptr stays advanced.
                if (!req_held) begin
                    gnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (state == INIT) begin
                    eng_init_nxt = 1'b1;
                    word_cnt_nxt = '0;
                    state_nxt    = STREAM;
                end else if (state == STREAM) begin
                    if (sel_valid) begin
                        if (!sel_last && word_cnt == WC_W'(MAX_WORDS)) begin
                            err_nxt   = 1'b1;
                            crc_nxt   = '0;
                            done_nxt  = gnt;
                            state_nxt = RESP;
                        end else begin
                            eng_valid_nxt = 1'b1;
                            eng_data_nxt  = sel_data;
                            eng_last_nxt  = sel_last;
                            word_cnt_nxt  = word_cnt + WC_W'(1);
                            if (sel_last) begin
                                tmo_cnt_nxt = '0;
                                state_nxt   = WAIT;
                            end
                        end
                    end
                end else begin
                    // eng_done beats a coincident timeout.
                    if (eng_done) begin
                        crc_nxt   = eng_result;
                        err_nxt   = 1'b0;
                        done_nxt  = gnt;
                        state_nxt = RESP;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        crc_nxt   = '0;
                        err_nxt   = 1'b1;
                        done_nxt  = gnt;
                        state_nxt = RESP;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
            end
            RESP: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= PTR_W'(NUM_REQ - 1);
            word_cnt   <= '0;
            tmo_cnt    <= '0;
            eng_init   <= 1'b0;
            eng_valid  <= 1'b0;
            eng_last   <= 1'b0;
            eng_data   <= '0;
            done       <= '0;
            err        <= 1'b0;
            crc_result <= '0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            rr_ptr     <= rr_ptr_nxt;
            word_cnt   <= word_cnt_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            eng_init   <= eng_init_nxt;
            eng_valid  <= eng_valid_nxt;
            eng_last   <= eng_last_nxt;
            eng_data   <= eng_data_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            crc_result <= crc_nxt;
        end
    end

endmodule

// File: tb/tb_crc16_arbiter.sv
// tb/tb_crc16_arbiter.sv - directed self-checking bench for crc16_arbiter
module tb_crc16_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_WORDS = 8;
    localparam int TIMEOUT   = 64;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req_valid, req_last;
    logic [63:0] req_data;
    logic [3:0]  gnt, done;
    logic        err, busy, eng_init, eng_valid, eng_last;
    logic [15:0] crc_result, eng_data;
    logic        eng_done;
    logic [15:0] eng_result;

    int checks = 0;
    int errors = 0;
    int n_init = 0, n_valid = 0, n_last = 0, n_done = 0;
    logic [15:0] data_q[$];
    logic [15:0] last_word = '0;
    logic        seen_dead = 1'b0;

    logic        eng_auto = 1'b1;
    logic [15:0] eng_val  = 16'hBEEF;
    int          eng_cd = 0;
    int          stray_req = 0, stray_ack = 0;

    crc16_arbiter #(.NUM_REQ(NUM_REQ), .MAX_WORDS(MAX_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .req        (req),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .crc_result (crc_result),
        .busy       (busy),
        .eng_init   (eng_init),
        .eng_valid  (eng_valid),
        .eng_data   (eng_data),
        .eng_last   (eng_last),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk_in = ~clk_in;

    // Engine model: result 3 cycles after eng_last, plus on-demand stray pulses.
    initial begin
        eng_done   = 1'b0;
        eng_result = '0;
        forever begin
            @(posedge clk_in);
            #2;
            eng_done   = 1'b0;
            eng_result = '0;
            if (eng_cd > 0) begin
                eng_cd--;
                if (eng_cd == 0) begin
                    eng_done   = 1'b1;
                    eng_result = eng_val;
                end
            end
            if (eng_last && eng_auto) eng_cd = 3;
            if (stray_req != stray_ack) begin
                stray_ack  = stray_req;
                eng_done   = 1'b1;
                eng_result = 16'h1111;
            end
        end
    end

    always @(negedge clk_in) begin
        if (eng_init) n_init <= n_init + 1;
        if (eng_valid) begin
            n_valid <= n_valid + 1;
            data_q.push_back(eng_data);
        end
        if (eng_last) begin
            n_last    <= n_last + 1;
            last_word <= eng_data;
        end
        if (done != 4'b0000) n_done <= n_done + 1;
        if (eng_data == 16'hDEAD) seen_dead <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_init(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            tick();
            if (eng_init) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (done != 4'b0000) ok = 1'b1;
        end
    endtask

    // Words are base, base+4444, ...; the final one carries last when use_last is set.
    task automatic stream(input logic [1:0] g, input int n, input logic use_last, input logic [15:0] base);
        logic [15:0] w_data;
        w_data = base;
        for (int w = 0; w < n; w++) begin
            req_valid[g]              = 1'b1;
            req_data[{g, 4'b0000} +: 16] = w_data;
            req_last[g]               = use_last && (w == n - 1);
            tick();
            w_data = w_data + 16'h4444;
        end
        req_valid[g] = 1'b0;
        req_last[g]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic       ok;
        int         i0, v0, l0, d0, n0, cyc;
        logic [3:0] g;
        logic [1:0] gi;

        rst_n = 1'b0; req = '0; req_valid = '0; req_last = '0; req_data = '0;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {err, busy, eng_init, eng_valid, eng_last}, 0);
        chk("rst_crc", crc_result, 0);
        chk("rst_eng_data", eng_data, 0);
        rst_n = 1'b1;
        tick();

        // Single requester, two words.
        i0 = data_q.size(); v0 = n_valid; l0 = n_last; n0 = n_init;
        req[0] = 1'b1;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_init_early", eng_init, 0);
        tick();
        chk("t1_init", eng_init, 1);
        stream(2'd0, 2, 1'b1, 16'h1234);
        wait_done(ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_done", done, 4'b0001);
        chk("t1_err", err, 0);
        chk("t1_crc", crc_result, 16'hBEEF);
        req[0] = 1'b0;
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_init_cnt", n_init - n0, 1);
        chk("t1_words", n_valid - v0, 2);
        chk("t1_last_cnt", n_last - l0, 1);
        chk("t1_word0", data_q[i0], 16'h1234);
        chk("t1_word1", data_q[i0+1], 16'h5678);
        chk("t1_last_word", last_word, 16'h5678);

        // Reset in the middle of STREAM.
        req[1] = 1'b1;
        wait_init(ok);
        chk("rs_gnt", gnt, 4'b0010);
        req_valid[1] = 1'b1;
        req_data[31:16] = 16'hAAAA;
        tick();
        chk("rs_fwd", eng_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_gnt0", gnt, 0);
        chk("rs_valid0", eng_valid, 0);
        chk("rs_busy0", busy, 0);
        req = '0; req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Contention: all four requesters, grant order from reset is 0,1,2,3.
        req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_init(ok);
            chk("cont_init_seen", ok, 1);
            g = gnt;
            chk($sformatf("cont_gnt%0d", k), g, 32'(1) << k);
            gi = 2'd0;
            for (int b = 0; b < 4; b++) if (g[b]) gi = 2'(b);
            stream(gi, 2, 1'b1, 16'h2000);
            wait_done(ok);
            chk("cont_done_seen", ok, 1);
            chk("cont_done", done, g);
            chk("cont_err", err, 0);
            req[gi] = 1'b0;
        end
        tick();
        req = 4'hF;
        wait_init(ok);
        chk("rr_wrap", gnt, 4'b0001);

        // Timeout: engine silent, single-word frame from requester 0.
        eng_auto = 1'b0;
        stream(2'd0, 1, 1'b1, 16'h5A5A);
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < TIMEOUT + 10) begin
            tick();
            cyc++;
            if (done != 4'b0000) ok = 1'b1;
        end
        chk("tmo_seen", ok, 1);
        chk("tmo_cycles", cyc, TIMEOUT);
        chk("tmo_done", done, 4'b0001);
        chk("tmo_err", err, 1);
        chk("tmo_crc", crc_result, 0);
        req[0] = 1'b0;
        eng_auto = 1'b1;
        wait_init(ok);
        chk("tmo_next_gnt", gnt, 4'b0010);

        // Overlength: nine words with no last.
        v0 = n_valid; l0 = n_last;
        stream(2'd1, 9, 1'b0, 16'h0100);
        chk("ovl_done", done, 4'b0010);
        chk("ovl_err", err, 1);
        chk("ovl_crc", crc_result, 0);
        chk("ovl_words", n_valid - v0, 8);
        chk("ovl_no_last", n_last - l0, 0);
        req[1] = 1'b0;

        // Abort from requester 2 while non-granted lane 1 drives traffic.
        req_valid[1] = 1'b1;
        req_data[31:16] = 16'hDEAD;
        wait_init(ok);
        chk("ab_gnt", gnt, 4'b0100);
        d0 = n_done;
        stream(2'd2, 3, 1'b0, 16'h3000);
        req = '0;
        tick();
        chk("ab_gnt0", gnt, 0);
        chk("ab_busy", busy, 0);
        tick();
        stray_req++;
        tick();
        tick();
        tick();
        chk("ab_no_done", n_done - d0, 0);
        chk("ab_stray_idle", busy, 0);
        chk("ab_no_leak", seen_dead, 0);
        req_valid = '0;
        req = 4'hF;
        wait_init(ok);
        chk("ab_rr_keep", gnt, 4'b1000);
        req = '0;
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc16_arbiter.md
Name: crc16_arbiter

Overview:
- Shares a single CRC16 engine between NUM_REQ frame-parser requesters, so one CRC calculator serves all parser lanes.
- Grants one requester per transaction using round-robin, and sequences the engine through init, word streaming and result wait.
- Returns the result and an error flag to the granted requester.
- Sits between the parser lanes and the CRC16 engine in the receive datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_WORDS, 8, maximum 16-bit words per transaction (128-bit payload).
- TIMEOUT, 64, cycles to wait for eng_done before declaring error.

Ports:
- clk_in  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester transaction request; held high until its done.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  marks final word, qualified by req_valid.
- req_data  in  NUM_REQ*16  flattened words; requester i uses [i*16 +: 16].
- gnt  out  NUM_REQ  one-hot grant, registered.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  valid with done; 1 = timeout or overlength.
- crc_result  out  16  valid with done; engine result, or 0 on err.
- busy  out  1  state != IDLE.
- eng_init  out  1  one-cycle pulse that clears the engine's CRC register.
- eng_valid  out  1  word strobe to the engine.
- eng_data  out  16  word to the engine.
- eng_last  out  1  final-word marker to the engine.
- eng_done  in  1  engine result-ready pulse.
- eng_result  in  16  engine CRC, valid with eng_done.

Behaviour:
- Reset values: all outputs 0. State = IDLE, rr_ptr = NUM_REQ-1, word_cnt = 0, tmo_cnt = 0.
- States and transitions:
  - IDLE: if any req is high, select the first set bit searching from rr_ptr+1 with wrap. Register gnt, set rr_ptr to the winner, go to INIT. If no req is high, stay.
  - INIT: assert eng_init for exactly one cycle, clear word_cnt, go to STREAM.
  - STREAM: eng_valid, eng_data and eng_last are registered copies of the granted requester's req_valid, req_data and req_last (1-cycle latency). word_cnt increments on each req_valid.
    - A word with req_last goes to WAIT (eng_last is asserted on the following cycle).
    - A req_valid with word_cnt == MAX_WORDS and no req_last (ninth word) is not forwarded. Set err, go to RESP.
  - WAIT: tmo_cnt increments each cycle.
    - eng_done: capture eng_result into crc_result, err = 0, go to RESP.
    - tmo_cnt reaching TIMEOUT-1 without eng_done: crc_result = 0, err = 1, go to RESP.
  - RESP: done[gnt] = 1 for one cycle, err and crc_result held valid. Next cycle: gnt = 0, done = 0, go to IDLE.
- Latency: req rising in IDLE gives gnt on the next edge and eng_init one cycle later. The first word is accepted in STREAM (2 cycles after req), and done follows 1 cycle after eng_done.
- Requester behaviour: req_valid from non-granted requesters is ignored. Requesters must hold req until done.
- Abort: if req[gnt] drops in INIT, STREAM or WAIT, go straight to IDLE.
  - No done pulse; gnt is cleared; rr_ptr keeps its advanced value.
  - A late eng_done arriving in IDLE is ignored.
- Simultaneous events:
  - eng_done in the same cycle as the timeout wins (result captured, err = 0).
  - req_last on word MAX_WORDS is legal.
  - req_last with word_cnt == 0 (single-word frame) is legal.
- eng_done outside WAIT is ignored in every state.
- Fairness: with all req high, grants rotate 0,1,2,...,NUM_REQ-1,0. A requester waits at most NUM_REQ-1 transactions.
- Reset asserted mid-operation: immediate return to the reset values. No pulse of done or eng_init is generated.

Decomposition:
- Package crc16_arb_pkg holds:
  - state_t enum {IDLE, INIT, STREAM, WAIT, RESP};
  - CRC_W = 16;
  - function rr_pick(req, ptr) returning a one-hot vector.
- One sub-module, rr_select: combinational round-robin picker (req, rr_ptr -> one-hot winner, any_req). It is reused by the planned FIFO output scheduler.

Test Plan:
- Single requester: req[0] sends words 16'h1234, 16'h5678 (last); the model engine returns 16'hBEEF 3 cycles after eng_last. Expect:
  - eng_init pulse once;
  - eng_data sequence 1234, 5678 with eng_last on the second word;
  - done[0] pulse with crc_result = BEEF, err = 0.
- Contention: req[0..3] all high, each sending 2 words. Expect gnt order 0,1,2,3, then rr_ptr = 3. Re-raising all four gives 0 next.
- Timeout: the engine never asserts eng_done. Expect done pulse exactly TIMEOUT cycles after entering WAIT, with err = 1 and crc_result = 0000; the next requester is then granted.
- Overlength: 9 valid words with no req_last. Expect only 8 eng_valid pulses, then done with err = 1; eng_last is never asserted.
- Abort and ignored traffic: req[2] drops after 3 words. Expect gnt cleared next cycle, no done, busy = 0. A stray eng_done 2 cycles later causes no pulse, and req_valid from the non-granted req[1] never reaches eng_data.
- Reset mid-STREAM: deassert rst_n. Expect gnt, eng_valid and busy at 0 immediately. After release, the first grant goes to requester 0.
